// File: rtl/calc_job_scheduler_pkg.sv
// Shared state encoding, calculator memory map and opcode set for the job scheduler.
package calc_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ISSUE,
      ST_GAP,
      ST_WAIT,
      ST_DONE
   } state_t;

   localparam logic [7:0] ADDR_A   = 8'd0;
   localparam logic [7:0] ADDR_B   = 8'd1;
   localparam logic [7:0] ADDR_SEL = 8'd2;

   // Step 3 of a job is the transfer start rather than a memory write.
   localparam logic [1:0] STEP_START = 2'd3;

   localparam logic [3:0] OP_0  = 4'd0;
   localparam logic [3:0] OP_1  = 4'd1;
   localparam logic [3:0] OP_2  = 4'd2;
   localparam logic [3:0] OP_3  = 4'd3;
   localparam logic [3:0] OP_4  = 4'd4;
   localparam logic [3:0] OP_5  = 4'd5;
   localparam logic [3:0] OP_6  = 4'd6;
   localparam logic [3:0] OP_7  = 4'd7;
   localparam logic [3:0] OP_8  = 4'd8;
   localparam logic [3:0] OP_11 = 4'd11;
   localparam logic [3:0] OP_12 = 4'd12;

   function automatic logic op_is_valid(input logic [3:0] op);
      case (op)
         OP_0, OP_1, OP_2, OP_3, OP_4, OP_5, OP_6, OP_7, OP_8, OP_11, OP_12:
            op_is_valid = 1'b1;
         default:
            op_is_valid = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/calc_job_scheduler_if.sv
// Requester fabric plus calculator host-port signals seen by the scheduler.
interface calc_job_scheduler_if;
   logic        Req0Valid;
   logic        Req1Valid;
   logic [7:0]  Req0A;
   logic [7:0]  Req0B;
   logic [7:0]  Req1A;
   logic [7:0]  Req1B;
   logic [3:0]  Req0Op;
   logic [3:0]  Req1Op;
   logic        Req0Ack;
   logic        Req1Ack;
   logic        Done;
   logic        DoneId;
   logic        Error;
   logic        SeqBusy;
   logic        ValidCmd;
   logic        Active;
   logic        Mode;
   logic        RW;
   logic [7:0]  Addr;
   logic [31:0] DataIn;
   logic        Busy;

   modport master (
      input  Req0Valid, Req1Valid, Req0A, Req0B, Req1A, Req1B, Req0Op, Req1Op, Busy,
      output Req0Ack, Req1Ack, Done, DoneId, Error, SeqBusy,
             ValidCmd, Active, Mode, RW, Addr, DataIn
   );

   modport slave (
      output Req0Valid, Req1Valid, Req0A, Req0B, Req1A, Req1B, Req0Op, Req1Op, Busy,
      input  Req0Ack, Req1Ack, Done, DoneId, Error, SeqBusy,
             ValidCmd, Active, Mode, RW, Addr, DataIn
   );
endinterface

// File: rtl/calc_job_scheduler_arb.sv
// Two-way round-robin arbiter; the pointer remembers the last granted requester.
module rr_arbiter2 (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

   logic r_last;

   always_comb begin
      o_gnt = 2'b00;
      if (i_en) begin
         if (i_req == 2'b11) begin
            o_gnt = r_last ? 2'b01 : 2'b10;
         end else begin
            o_gnt = i_req;
         end
      end
   end

   // Pointer resets to 1 so requester 0 wins the first contended grant.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_last <= 1'b1;
      end else if (o_gnt != 2'b00) begin
         r_last <= o_gnt[1];
      end
   end

endmodule

// File: rtl/calc_job_scheduler.sv
// Shares one Binary_Calculator between two requesters: writes A, B and Sel to
// addresses 0..2, starts the transfer, and paces every command on Busy.
module calc_job_scheduler
   import calc_seq_pkg::*;
#(
   parameter int GAP     = 2,
   parameter int TIMEOUT = 2000
) (
   input  logic                 Clk,
   input  logic                 Rst,
   calc_job_scheduler_if.master bus
);

   localparam int CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           r_state, w_state_nxt;
   logic [1:0]       r_step,  w_step_nxt;
   logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
   logic             r_err,   w_err_nxt;
   logic [7:0]       r_a;
   logic [7:0]       r_b;
   logic [3:0]       r_op;
   logic             r_id;
   logic             w_arb_en;
   logic [1:0]       w_gnt;
   logic             w_grant;
   logic             w_cmd_phase;

   assign w_arb_en = (r_state == ST_IDLE) && !bus.Busy;
   assign w_grant  = |w_gnt;

   rr_arbiter2 u_arb (
      .i_clk (Clk),
      .i_rst (Rst),
      .i_en  (w_arb_en),
      .i_req ({bus.Req1Valid, bus.Req0Valid}),
      .o_gnt (w_gnt)
   );

   // Job fields are captured on the granting edge; they are only observed
   // while a job is in flight, so they carry no reset.
   always_ff @(posedge Clk) begin
      if (w_grant) begin
         r_a  <= w_gnt[1] ? bus.Req1A  : bus.Req0A;
         r_b  <= w_gnt[1] ? bus.Req1B  : bus.Req0B;
         r_op <= w_gnt[1] ? bus.Req1Op : bus.Req0Op;
         r_id <= w_gnt[1];
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state <= ST_IDLE;
         r_step  <= 2'd0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_step  <= w_step_nxt;
         r_cnt   <= w_cnt_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = r_err;
      case (r_state)
         ST_IDLE: begin
            if (w_grant) begin
               w_state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            w_step_nxt = 2'd0;
            w_cnt_nxt  = '0;
            if (op_is_valid(r_op)) begin
               w_state_nxt = ST_ISSUE;
               w_err_nxt   = 1'b0;
            end else begin
               w_state_nxt = ST_DONE;
               w_err_nxt   = 1'b1;
            end
         end
         ST_ISSUE: begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = '0;
         end
         ST_GAP: begin
            // Busy is deliberately not looked at here; the calculator needs
            // a few cycles before its Busy reflects the command just issued.
            if (r_cnt == GAP_LAST) begin
               w_state_nxt = ST_WAIT;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_WAIT: begin
            if (!bus.Busy) begin
               w_cnt_nxt = '0;
               if (r_step == STEP_START) begin
                  w_state_nxt = ST_DONE;
                  w_err_nxt   = 1'b0;
               end else begin
                  w_state_nxt = ST_ISSUE;
                  w_step_nxt  = r_step + 2'd1;
               end
            end else if (r_cnt == WAIT_LAST) begin
               w_state_nxt = ST_DONE;
               w_err_nxt   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
            w_step_nxt  = 2'd0;
            w_cnt_nxt   = '0;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_cmd_phase = (r_state == ST_ISSUE) || (r_state == ST_GAP) || (r_state == ST_WAIT);

   // Command fields follow the step for the whole ISSUE/GAP/WAIT window.
   always_comb begin
      bus.Mode   = 1'b0;
      bus.RW     = 1'b0;
      bus.Addr   = 8'd0;
      bus.DataIn = 32'd0;
      if (w_cmd_phase) begin
         case (r_step)
            2'd0: begin
               bus.Mode   = 1'b1;
               bus.RW     = 1'b1;
               bus.Addr   = ADDR_A;
               bus.DataIn = {24'd0, r_a};
            end
            2'd1: begin
               bus.Mode   = 1'b1;
               bus.RW     = 1'b1;
               bus.Addr   = ADDR_B;
               bus.DataIn = {24'd0, r_b};
            end
            2'd2: begin
               bus.Mode   = 1'b1;
               bus.RW     = 1'b1;
               bus.Addr   = ADDR_SEL;
               bus.DataIn = {28'd0, r_op};
            end
            default: begin
               bus.Mode   = 1'b0;
               bus.RW     = 1'b0;
               bus.Addr   = 8'd0;
               bus.DataIn = 32'd0;
            end
         endcase
      end
   end

   always_comb begin
      bus.ValidCmd = (r_state == ST_ISSUE);
      bus.Active   = (r_state == ST_ISSUE);
      bus.Req0Ack  = (r_state == ST_LOAD) && !r_id;
      bus.Req1Ack  = (r_state == ST_LOAD) &&  r_id;
      bus.Done     = (r_state == ST_DONE);
      bus.DoneId   = (r_state == ST_DONE) && r_id;
      bus.Error    = (r_state == ST_DONE) && r_err;
      bus.SeqBusy  = (r_state != ST_IDLE);
   end

endmodule

// File: tb/tb_calc_job_scheduler.sv
// Bench for calc_job_scheduler: directed scenarios plus random jobs checked
// against a job-level model of command order, latency and arbitration.
module tb_calc_job_scheduler;

   localparam int GAP     = 2;
   localparam int TIMEOUT = 20;

   typedef struct {
      logic        mode;
      logic        rw;
      logic        active;
      logic [7:0]  addr;
      logic [31:0] data;
      int          t;
   } cmd_t;

   logic clk        = 1'b0;
   logic rst        = 1'b1;
   int   cyc        = 0;
   int   n_tests    = 0;
   int   n_fail     = 0;
   int   busy_len   = 0;
   logic busy_force = 1'b0;
   int   bcnt       = 0;
   bit   model_last = 1'b1;

   cmd_t       cmdq[$];
   int         ack_t[$];
   logic       ack_id[$];
   int         done_t[$];
   logic       done_id[$];
   logic       done_err[$];
   logic [7:0] calc_mem [3];
   logic [7:0] calc_out = 8'd0;

   calc_job_scheduler_if bus ();

   calc_job_scheduler #(.GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Calculator stand-in: Busy for busy_len cycles after each command strobe.
   always @(posedge clk or posedge rst) begin
      if (rst) bcnt <= 0;
      else if (bus.ValidCmd) bcnt <= busy_len;
      else if (bcnt > 0) bcnt <= bcnt - 1;
   end
   assign bus.Busy = (bcnt != 0) || busy_force;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.ValidCmd) begin
            cmdq.push_back('{mode: bus.Mode, rw: bus.RW, active: bus.Active,
                             addr: bus.Addr, data: bus.DataIn, t: cyc});
            if (bus.Mode && bus.RW && bus.Addr < 8'd3) calc_mem[bus.Addr[1:0]] = bus.DataIn[7:0];
            else if (!bus.Mode && !bus.RW && calc_mem[2] == 8'd0) calc_out = calc_mem[0] + calc_mem[1];
         end
         if (bus.Req0Ack) begin ack_t.push_back(cyc); ack_id.push_back(1'b0); end
         if (bus.Req1Ack) begin ack_t.push_back(cyc); ack_id.push_back(1'b1); end
         if (bus.Done) begin
            done_t.push_back(cyc);
            done_id.push_back(bus.DoneId);
            done_err.push_back(bus.Error);
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] outs_vec();
      return 64'({bus.Req0Ack, bus.Req1Ack, bus.Done, bus.DoneId, bus.Error, bus.SeqBusy,
                  bus.ValidCmd, bus.Active, bus.Mode, bus.RW, bus.Addr, bus.DataIn});
   endfunction

   function automatic bit model_op_ok(input logic [3:0] op);
      return (op <= 4'd8) || (op == 4'd11) || (op == 4'd12);
   endfunction

   // Busy high for blen cycles after a strobe; WAIT lasts until it clears (at least one cycle).
   function automatic int model_latency(input bit ok, input int blen);
      int wait_c;
      if (!ok) return 1;
      wait_c = blen - GAP + 1;
      if (wait_c < 1) wait_c = 1;
      return 4 * (1 + GAP + wait_c) + 1;
   endfunction

   function automatic logic [63:0] model_cmd(input int k, input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] op);
      case (k)
         0:       return 64'({1'b1, 1'b1, 8'd0, 24'd0, a});
         1:       return 64'({1'b1, 1'b1, 8'd1, 24'd0, b});
         2:       return 64'({1'b1, 1'b1, 8'd2, 28'd0, op});
         default: return 64'd0;
      endcase
   endfunction

   task automatic drive_req(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      if (id) begin
         bus.Req1A = a; bus.Req1B = b; bus.Req1Op = op; bus.Req1Valid = 1'b1;
      end else begin
         bus.Req0A = a; bus.Req0B = b; bus.Req0Op = op; bus.Req0Valid = 1'b1;
      end
   endtask

   task automatic run_job(input string tag, input bit id, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] op, input int blen);
      int c_base, a_base, d_base, t_go, n_exp;
      bit ok;
      c_base   = cmdq.size();
      a_base   = ack_t.size();
      d_base   = done_t.size();
      busy_len = blen;
      ok       = model_op_ok(op);
      n_exp    = ok ? 4 : 0;
      tick();
      drive_req(id, a, b, op);
      t_go = cyc;
      for (int i = 0; i < 300 && done_t.size() == d_base; i++) begin
         tick();
         if (ack_t.size() > a_base) begin bus.Req0Valid = 1'b0; bus.Req1Valid = 1'b0; end
      end
      bus.Req0Valid = 1'b0;
      bus.Req1Valid = 1'b0;
      check({tag, "/done_count"}, 64'(done_t.size() - d_base), 64'd1);
      check({tag, "/ack_count"}, 64'(ack_t.size() - a_base), 64'd1);
      if (ack_t.size() > a_base) begin
         check({tag, "/ack_id"}, 64'(ack_id[a_base]), 64'(id));
         check({tag, "/ack_latency"}, 64'(ack_t[a_base] - t_go), 64'd1);
         if (done_t.size() > d_base) begin
            check({tag, "/done_latency"}, 64'(done_t[d_base] - ack_t[a_base]), 64'(model_latency(ok, blen)));
         end
      end
      if (done_t.size() > d_base) begin
         check({tag, "/done_id"}, 64'(done_id[d_base]), 64'(id));
         check({tag, "/done_err"}, 64'(done_err[d_base]), 64'(!ok));
      end
      check({tag, "/cmd_count"}, 64'(cmdq.size() - c_base), 64'(n_exp));
      for (int k = 0; k < n_exp && c_base + k < cmdq.size(); k++) begin
         check({tag, "/cmd"}, 64'({cmdq[c_base+k].mode, cmdq[c_base+k].rw, cmdq[c_base+k].addr,
                                   cmdq[c_base+k].data}), model_cmd(k, a, b, op));
         check({tag, "/active"}, 64'(cmdq[c_base+k].active), 64'd1);
      end
      model_last = id;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a_base, d_base, c_base, p, n0, n1, r0, r1, t_rel;
      bit w, found;
      logic [7:0] ra, rb;
      logic [3:0] rop;

      bus.Req0Valid = 1'b0; bus.Req1Valid = 1'b0;
      bus.Req0A = 8'd0; bus.Req0B = 8'd0; bus.Req0Op = 4'd0;
      bus.Req1A = 8'd0; bus.Req1B = 8'd0; bus.Req1Op = 4'd0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset/outputs", outs_vec(), 64'd0);
      @(negedge clk) rst = 1'b0;
      tick();
      check("reset/idle_after_release", outs_vec(), 64'd0);

      // Single job, calculator busy 3 cycles per command
      run_job("single", 1'b0, 8'd8, 8'd2, 4'd0, 3);
      check("single/alu_out", 64'(calc_out), 64'd10);

      // Bad opcode from requester 1
      run_job("badop", 1'b1, 8'h5A, 8'hA5, 4'd9, 0);

      // Contention: both requesters continuously valid, two jobs each
      a_base = ack_t.size(); d_base = done_t.size(); p = a_base; n0 = 0; n1 = 0;
      busy_len = int'($urandom_range(0, 4));
      tick();
      drive_req(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'd0);
      drive_req(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'd0);
      for (int i = 0; i < 600 && done_t.size() - d_base < 4; i++) begin
         tick();
         while (p < ack_t.size()) begin
            if (ack_id[p]) begin n1++; if (n1 == 2) bus.Req1Valid = 1'b0; end
            else begin n0++; if (n0 == 2) bus.Req0Valid = 1'b0; end
            p++;
         end
      end
      bus.Req0Valid = 1'b0; bus.Req1Valid = 1'b0;
      check("contend/acks_req0", 64'(n0), 64'd2);
      check("contend/acks_req1", 64'(n1), 64'd2);
      r0 = 2; r1 = 2;
      for (int j = 0; j < 4 && a_base + j < ack_t.size(); j++) begin
         w = (r0 > 0 && r1 > 0) ? !model_last : (r0 > 0 ? 1'b0 : 1'b1);
         check("contend/grant_order", 64'(ack_id[a_base+j]), 64'(w));
         if (w) r1--; else r0--;
         model_last = w;
      end
      for (int j = 0; j < 4 && d_base + j < done_t.size(); j++) begin
         check("contend/done_err", 64'(done_err[d_base+j]), 64'd0);
      end

      // Timeout: Busy stuck high from the second command onwards
      c_base = cmdq.size(); a_base = ack_t.size(); d_base = done_t.size();
      busy_len = 0;
      tick();
      drive_req(1'b0, 8'd3, 8'd4, 4'd1);
      for (int i = 0; i < 300 && done_t.size() == d_base; i++) begin
         tick();
         if (ack_t.size() > a_base) bus.Req0Valid = 1'b0;
         if (cmdq.size() - c_base >= 2) busy_force = 1'b1;
      end
      busy_force = 1'b0;
      bus.Req0Valid = 1'b0;
      check("timeout/done_count", 64'(done_t.size() - d_base), 64'd1);
      check("timeout/cmd_count", 64'(cmdq.size() - c_base), 64'd2);
      if (done_t.size() > d_base && cmdq.size() - c_base >= 2) begin
         check("timeout/err", 64'(done_err[d_base]), 64'd1);
         check("timeout/id", 64'(done_id[d_base]), 64'd0);
         check("timeout/cycles", 64'(done_t[d_base] - cmdq[c_base+1].t), 64'(1 + GAP + TIMEOUT));
      end
      model_last = 1'b0;

      // Randomised jobs against the model
      for (int n = 0; n < 10; n++) begin
         ra  = 8'($urandom_range(0, 255));
         rb  = 8'($urandom_range(0, 255));
         rop = 4'($urandom_range(0, 15));
         run_job("random", 1'($urandom_range(0, 1)), ra, rb, rop, int'($urandom_range(0, 5)));
      end

      // Busy at idle blocks arbitration
      a_base = ack_t.size(); d_base = done_t.size();
      busy_len = 0;
      busy_force = 1'b1;
      tick();
      drive_req(1'b0, 8'd1, 8'd1, 4'd2);
      repeat (6) tick();
      check("busyidle/no_ack", 64'(ack_t.size() - a_base), 64'd0);
      busy_force = 1'b0;
      t_rel = cyc;
      for (int i = 0; i < 100 && done_t.size() == d_base; i++) begin
         tick();
         if (ack_t.size() > a_base) bus.Req0Valid = 1'b0;
      end
      bus.Req0Valid = 1'b0;
      check("busyidle/done_count", 64'(done_t.size() - d_base), 64'd1);
      if (ack_t.size() > a_base && done_t.size() > d_base) begin
         check("busyidle/ack_latency", 64'(ack_t[a_base] - t_rel), 64'd1);
         check("busyidle/done_latency", 64'(done_t[d_base] - ack_t[a_base]), 64'd17);
      end

      // Reset in the middle of the Sel write
      d_base = done_t.size();
      busy_len = 0;
      tick();
      drive_req(1'b0, 8'd7, 8'd9, 4'd0);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (bus.Req0Ack) bus.Req0Valid = 1'b0;
         if (bus.ValidCmd && bus.Addr == 8'd2) found = 1'b1;
      end
      check("rstmid/sel_reached", 64'(found), 64'd1);
      #1 rst = 1'b1;
      #1;
      check("rstmid/validcmd", 64'(bus.ValidCmd), 64'd0);
      check("rstmid/outputs", outs_vec(), 64'd0);
      bus.Req0Valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (3) tick();
      check("rstmid/no_done", 64'(done_t.size() - d_base), 64'd0);

      a_base = ack_t.size(); d_base = done_t.size(); p = a_base;
      tick();
      drive_req(1'b0, 8'd2, 8'd2, 4'd0);
      drive_req(1'b1, 8'd4, 8'd4, 4'd0);
      for (int i = 0; i < 200 && done_t.size() - d_base < 2; i++) begin
         tick();
         while (p < ack_t.size()) begin
            if (ack_id[p]) bus.Req1Valid = 1'b0; else bus.Req0Valid = 1'b0;
            p++;
         end
      end
      bus.Req0Valid = 1'b0; bus.Req1Valid = 1'b0;
      check("rstmid/post_done_count", 64'(done_t.size() - d_base), 64'd2);
      if (ack_t.size() - a_base >= 2) begin
         check("rstmid/first_grant", 64'(ack_id[a_base]), 64'd0);
         check("rstmid/second_grant", 64'(ack_id[a_base+1]), 64'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/calc_job_scheduler.md
# calc_job_scheduler

Shares one Binary_Calculator between two job requesters. Each job is an operand pair plus an ALU opcode. The scheduler picks requesters round-robin and drives the calculator's host command port to write A, B and Sel into memory at addresses 0, 1 and 2. It then starts a serial transfer and waits for the calculator's Busy to clear after every command. It sits between the requester fabric and the calculator's host port, replacing direct host access.

## Interface
- GAP, 2: cycles waited after each issued command before Busy is sampled (≥1)
- TIMEOUT, 2000: maximum cycles in WAIT before the job is aborted
- Clk  in  1  single clock, all logic on posedge
- Rst  in  1  asynchronous, active-high reset
- Req0Valid / Req1Valid  in  1  job request; held until Ack
- Req0A, Req0B / Req1A, Req1B  in  8  operands
- Req0Op / Req1Op  in  4  ALU opcode
- Req0Ack / Req1Ack  out  1  one-cycle pulse when the job is latched
- Done  out  1  one-cycle job-complete pulse
- DoneId  out  1  requester index of the completed job, valid with Done
- Error  out  1  valid with Done: bad opcode or timeout
- SeqBusy  out  1  high from LOAD through DONE
- ValidCmd, Active  out  1  calculator command strobe, one cycle per command
- Mode, RW  out  1  calculator command type
- Addr  out  8  calculator address
- DataIn  out  32  calculator write data
- Busy  in  1  calculator busy

## Operation
- States: IDLE, LOAD, ISSUE, GAP, WAIT, DONE. A 2-bit step counter selects the command: 0 writes A, 1 writes B, 2 writes Sel, 3 starts the transfer.
- IDLE: arbitrate only when Busy=0 and at least one Valid is high.
  - With one request, it wins.
  - With both, the requester not granted last wins. The last-grant pointer resets to 1, so Req0 wins first.
  - At the edge the grant is made, latch A, B, Op and the requester index, then go to LOAD.
- LOAD: the granted requester's Ack=1. Check the opcode:
  - Valid opcodes are 0–8, 11 and 12. A valid opcode goes to ISSUE with step=0.
  - Any other opcode goes to DONE with Error=1 and issues no calculator traffic.
- ISSUE: ValidCmd=Active=1 for one cycle.
  - Steps 0–2: Mode=1, RW=1, Addr=step. DataIn is zero-extended A, B or Op.
  - Step 3: Mode=0, RW=0, Addr=0, DataIn=0.
  - Mode, RW, Addr and DataIn hold through GAP and WAIT, and are 0 in IDLE.
- GAP: count GAP cycles, then go to WAIT.
- WAIT: when Busy=0 is sampled, step<3 goes to ISSUE with step+1, and step=3 goes to DONE with Error=0. If the WAIT counter reaches TIMEOUT, go to DONE with Error=1.
- DONE: Done=1, DoneId=index and Error as set, for one cycle. Then go to IDLE.
- A requester that drops Valid before a grant is never granted. Valid is ignored while SeqBusy=1.

## Timing
- During reset, all outputs are 0, the state is IDLE, step=0 and the pointer=1. A reset mid-job discards the job: no Done, ValidCmd drops immediately.
- Ack occurs in the cycle after the granting edge; there is no combinational path from Valid to Ack.
- With Busy never high, each step takes GAP+2 cycles. Done rises 4·(GAP+2)+1 cycles after the Ack cycle, which is 17 with GAP=2.
- A bad opcode gives Done in the cycle after Ack.
- A new grant is possible at the edge after DONE, so back-to-back jobs are separated by a single IDLE cycle.
- Busy is sampled only in IDLE and WAIT. A Busy glitch during GAP is ignored.

## Structure
- Package calc_seq_pkg holds:
  - the state enum;
  - the constants ADDR_A=0, ADDR_B=1, ADDR_SEL=2;
  - the opcode constants 0–8, 11 and 12;
  - the function op_is_valid(op).
- Sub-module rr_arbiter2: two request inputs, a registered last-grant pointer, grant one-hot and an enable input. The scheduler enables it only in IDLE with Busy=0.

## Test plan
- Single job: Req0 A=8, B=2, Op=0 with a Busy model (high for 3 cycles per command).
  - Required: four ValidCmd pulses in order: Addr 0/Data 8, Addr 1/Data 2, Addr 2/Data 0, then Mode=0.
  - Required: Done with DoneId=0, Error=0, and the calculator ALU Out=10.
- Contention: Req0 and Req1 both valid continuously with 2 jobs each.
  - Required: grants alternate 0, 1, 0, 1.
  - Required: the Ack count per requester equals 2.
- Bad opcode: Req1 Op=9 → Ack, then Done in the next cycle with DoneId=1, Error=1, and no ValidCmd.
- Timeout: Busy held high after the second command, with TIMEOUT=20 → Done with Error=1 exactly 20 cycles after entering WAIT, and no third command issued.
- Reset mid-job: Rst asserted during the Sel write →
  - all outputs 0 in the same cycle;
  - after release, Req0 is granted first.
- Busy at idle: Busy=1 with Req0Valid=1 → no Ack until Busy=0. Then Ack one cycle later, and Done 17 cycles after Ack with Busy low.
